// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - shared types and constants for the serial pattern generator
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } gen_state_t;

  localparam int          DEFAULT_PAT_W = 4;
  localparam logic [3:0]  DEFAULT_PAT   = 4'b1010;

  // Bit-index counter width; a 1-bit floor keeps degenerate widths legal
  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/pat_piso.sv
// rtl/pat_piso.sv - parallel-load, MSB-first rotating shift register
module pat_piso #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         msb
);

  logic [W-1:0] sr;

  // Rotating rather than shifting lets every repetition reuse the loaded pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= d;
    end else if (shift) begin
      sr <= {sr[W-2:0], sr[W-1]};
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial pattern transmitter with repeat count and fill gaps
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int               PAT_W       = DEFAULT_PAT_W,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = DEFAULT_PAT,
  parameter int               CNT_W       = 8,
  parameter int               GAP_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             use_default,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_bits,
  input  logic             fill_bit,
  input  logic             abort,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = idx_w(PAT_W);

  gen_state_t       state, state_nxt;
  logic [BIT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] rep_left;
  logic [GAP_W-1:0] gap_left;
  logic [GAP_W-1:0] gap_cfg;
  logic             fill_q;
  logic [PAT_W-1:0] pat_sel;
  logic             accept, last_bit, more_reps;
  logic             piso_shift, piso_msb;
  logic             x_d, x_valid_d, busy_d, done_d;

  assign pat_sel    = use_default ? PAT_DEFAULT : pattern;
  assign accept     = (state == IDLE) && start && !abort;
  assign last_bit   = (bit_cnt == BIT_W'(PAT_W - 1));
  assign more_reps  = (rep_left > CNT_W'(1));
  assign piso_shift = (state != IDLE) && (state_nxt == SHIFT);

  // Loaded pre-rotated: the MSB goes straight to x_out, so the register holds the next bit
  pat_piso #(.W(PAT_W)) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift (piso_shift),
    .d     ({pat_sel[PAT_W-2:0], pat_sel[PAT_W-1]}),
    .msb   (piso_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      x_out   <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      x_out   <= x_d;
      x_valid <= x_valid_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (repeat_cnt != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (abort)                state_nxt = IDLE;
        else if (last_bit)        state_nxt = !more_reps ? DONE :
                                              (gap_cfg != '0) ? GAP : SHIFT;
      end
      GAP: begin
        if (abort)                         state_nxt = IDLE;
        else if (gap_left == GAP_W'(1))    state_nxt = SHIFT;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_nxt)
      SHIFT: begin
        x_d       = (state == IDLE) ? pat_sel[PAT_W-1] : piso_msb;
        x_valid_d = 1'b1;
        busy_d    = 1'b1;
      end
      GAP: begin
        x_d    = fill_q;
        busy_d = 1'b1;
      end
      // A zero-repeat frame still shows busy for its single DONE cycle
      DONE: begin
        done_d = 1'b1;
        busy_d = (state == IDLE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      rep_left <= '0;
      gap_left <= '0;
      gap_cfg  <= '0;
      fill_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rep_left <= repeat_cnt;
            gap_cfg  <= gap_bits;
            fill_q   <= fill_bit;
            bit_cnt  <= '0;
            gap_left <= '0;
          end
        end
        SHIFT: begin
          if (abort) begin
            bit_cnt  <= '0;
            rep_left <= '0;
            gap_left <= '0;
          end else begin
            bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
            if (last_bit) rep_left <= rep_left - CNT_W'(1);
            if (state_nxt == GAP) gap_left <= gap_cfg;
          end
        end
        GAP: begin
          if (abort) begin
            rep_left <= '0;
            gap_left <= '0;
          end else begin
            gap_left <= gap_left - GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - directed self-checking bench for seq_pattern_gen
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, use_default, fill_bit, abort;
  logic [3:0] pattern;
  logic [7:0] repeat_cnt;
  logic [3:0] gap_bits;
  logic       x_out, x_valid, busy, done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] xs, vs, bs, ds;

  seq_pattern_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .use_default (use_default),
    .pattern     (pattern),
    .repeat_cnt  (repeat_cnt),
    .gap_bits    (gap_bits),
    .fill_bit    (fill_bit),
    .abort       (abort),
    .x_out       (x_out),
    .x_valid     (x_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Drives one start pulse; returns during cycle 1 of the frame
  task automatic pulse_start(input logic ud, input logic [3:0] pat, input logic [7:0] rc,
                             input logic [3:0] gb, input logic fb);
    use_default = ud;
    pattern     = pat;
    repeat_cnt  = rc;
    gap_bits    = gb;
    fill_bit    = fb;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Records n cycles; the first sampled cycle ends up in bit n-1
  task automatic capture(input int n);
    xs = '0; vs = '0; bs = '0; ds = '0;
    for (int i = 0; i < n; i++) begin
      xs = {xs[30:0], x_out};
      vs = {vs[30:0], x_valid};
      bs = {bs[30:0], busy};
      ds = {ds[30:0], done};
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; use_default = 1'b0;
    pattern = '0; repeat_cnt = '0; gap_bits = '0; fill_bit = 1'b0;
    #1;
    checks++;
    if ({x_out, x_valid, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000", {x_out, x_valid, busy, done});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    capture(3);
    checks++;
    if (bs[2:0] !== 3'b000 || vs[2:0] !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle busy=%b valid=%b exp=000", bs[2:0], vs[2:0]);
    end
  endtask

  task automatic test_default();
    pulse_start(1'b1, 4'b0000, 8'd1, 4'd0, 1'b0);
    capture(6);
    checks++;
    if (xs[5:0] !== 6'b101000) begin
      failures++; $display("FAIL default_x got=%b exp=101000", xs[5:0]);
    end
    checks++;
    if (vs[5:0] !== 6'b111100) begin
      failures++; $display("FAIL default_valid got=%b exp=111100", vs[5:0]);
    end
    checks++;
    if (bs[5:0] !== 6'b111100) begin
      failures++; $display("FAIL default_busy got=%b exp=111100", bs[5:0]);
    end
    checks++;
    if (ds[5:0] !== 6'b000010) begin
      failures++; $display("FAIL default_done got=%b exp=000010", ds[5:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  win;
    int          nbits;
    logic [15:0] fires;
    pulse_start(1'b0, 4'b1010, 8'd2, 4'd0, 1'b0);
    capture(10);
    checks++;
    if (xs[9:0] !== 10'b1010101000) begin
      failures++; $display("FAIL b2b_x got=%b exp=1010101000", xs[9:0]);
    end
    checks++;
    if (vs[9:0] !== 10'b1111111100) begin
      failures++; $display("FAIL b2b_valid got=%b exp=1111111100", vs[9:0]);
    end
    checks++;
    if (ds[9:0] !== 10'b0000000010) begin
      failures++; $display("FAIL b2b_done got=%b exp=0000000010", ds[9:0]);
    end
    win = '0; nbits = 0; fires = '0;
    for (int i = 9; i >= 0; i--) begin
      if (vs[i]) begin
        win = {win[2:0], xs[i]};
        nbits++;
        if (nbits >= 4 && win == 4'b1010) fires[nbits] = 1'b1;
      end
    end
    checks++;
    if (fires !== 16'h0150) begin
      failures++; $display("FAIL b2b_detector got=%h exp=0150", fires);
    end
  endtask

  task automatic test_gap();
    pulse_start(1'b0, 4'b1010, 8'd3, 4'd2, 1'b0);
    capture(18);
    checks++;
    if (xs[17:0] !== 18'b101000101000101000) begin
      failures++; $display("FAIL gap_x got=%b exp=101000101000101000", xs[17:0]);
    end
    checks++;
    if (vs[17:0] !== 18'b111100111100111100) begin
      failures++; $display("FAIL gap_valid got=%b exp=111100111100111100", vs[17:0]);
    end
    checks++;
    if (bs[17:0] !== 18'b111111111111111100) begin
      failures++; $display("FAIL gap_busy got=%b exp=111111111111111100", bs[17:0]);
    end
    checks++;
    if (ds[17:0] !== 18'b000000000000000010) begin
      failures++; $display("FAIL gap_done got=%b exp=000000000000000010", ds[17:0]);
    end
    pulse_start(1'b0, 4'b0110, 8'd2, 4'd1, 1'b1);
    capture(11);
    checks++;
    if (xs[10:0] !== 11'b01101011000) begin
      failures++; $display("FAIL fill1_x got=%b exp=01101011000", xs[10:0]);
    end
    checks++;
    if (vs[10:0] !== 11'b11110111100 || ds[10:0] !== 11'b00000000010) begin
      failures++;
      $display("FAIL fill1_ctrl valid=%b done=%b exp=11110111100/00000000010", vs[10:0], ds[10:0]);
    end
  endtask

  task automatic test_zero_and_restart();
    pulse_start(1'b0, 4'b1111, 8'd0, 4'd3, 1'b1);
    capture(2);
    checks++;
    if (bs[1:0] !== 2'b10 || ds[1:0] !== 2'b10 || vs[1:0] !== 2'b00 || xs[1:0] !== 2'b00) begin
      failures++;
      $display("FAIL zero_rep busy=%b done=%b valid=%b x=%b exp=10/10/00/00",
               bs[1:0], ds[1:0], vs[1:0], xs[1:0]);
    end
    pulse_start(1'b0, 4'b1100, 8'd2, 4'd1, 1'b0);
    xs = '0; vs = '0; bs = '0; ds = '0;
    for (int i = 1; i <= 11; i++) begin
      xs = {xs[30:0], x_out};
      vs = {vs[30:0], x_valid};
      bs = {bs[30:0], busy};
      ds = {ds[30:0], done};
      if (i == 3) begin
        start = 1'b1; use_default = 1'b1; pattern = 4'b0011;
        repeat_cnt = 8'd5; gap_bits = 4'd0; fill_bit = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks++;
    if (xs[10:0] !== 11'b11000110000) begin
      failures++; $display("FAIL midstart_x got=%b exp=11000110000", xs[10:0]);
    end
    checks++;
    if (bs[10:0] !== 11'b11111111100 || ds[10:0] !== 11'b00000000010) begin
      failures++;
      $display("FAIL midstart_len busy=%b done=%b exp=11111111100/00000000010", bs[10:0], ds[10:0]);
    end
  endtask

  task automatic test_abort();
    pulse_start(1'b0, 4'b1010, 8'd2, 4'd0, 1'b0);
    xs = '0; vs = '0; bs = '0; ds = '0;
    for (int i = 1; i <= 12; i++) begin
      xs = {xs[30:0], x_out};
      vs = {vs[30:0], x_valid};
      bs = {bs[30:0], busy};
      ds = {ds[30:0], done};
      if (i == 3) abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
    checks++;
    if (xs[11:0] !== 12'b101000000000 || vs[11:0] !== 12'b111000000000) begin
      failures++;
      $display("FAIL abort_stream x=%b valid=%b exp=101000000000/111000000000", xs[11:0], vs[11:0]);
    end
    checks++;
    if (bs[11:0] !== 12'b111000000000 || ds[11:0] !== 12'b000000000000) begin
      failures++;
      $display("FAIL abort_ctrl busy=%b done=%b exp=111000000000/000000000000", bs[11:0], ds[11:0]);
    end
    use_default = 1'b0; pattern = 4'b1001; repeat_cnt = 8'd1; gap_bits = 4'd0;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    capture(3);
    checks++;
    if (bs[2:0] !== 3'b000 || vs[2:0] !== 3'b000 || ds[2:0] !== 3'b000) begin
      failures++;
      $display("FAIL abort_wins busy=%b valid=%b done=%b exp=000", bs[2:0], vs[2:0], ds[2:0]);
    end
    pulse_start(1'b0, 4'b1001, 8'd1, 4'd0, 1'b0);
    capture(5);
    checks++;
    if (xs[4:0] !== 5'b10010 || ds[4:0] !== 5'b00001) begin
      failures++;
      $display("FAIL abort_restart x=%b done=%b exp=10010/00001", xs[4:0], ds[4:0]);
    end
  endtask

  task automatic test_reset_mid_gap();
    pulse_start(1'b0, 4'b1010, 8'd2, 4'd3, 1'b1);
    repeat (5) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({x_out, x_valid, busy} !== 3'b101) begin
      failures++; $display("FAIL pre_reset_gap got=%b exp=101", {x_out, x_valid, busy});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({x_out, x_valid, busy, done} !== 4'b0000) begin
      failures++; $display("FAIL async_reset got=%b exp=0000", {x_out, x_valid, busy, done});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    capture(4);
    checks++;
    if (bs[3:0] !== 4'b0000 || vs[3:0] !== 4'b0000 || ds[3:0] !== 4'b0000 || xs[3:0] !== 4'b0000) begin
      failures++;
      $display("FAIL post_reset_idle busy=%b valid=%b done=%b x=%b exp=0000",
               bs[3:0], vs[3:0], ds[3:0], xs[3:0]);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_back_to_back();
    test_gap();
    test_zero_and_restart();
    test_abort();
    test_reset_mid_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
